// File: rtl/sw_pkg.sv
// sw_pkg: constants and types shared between the switch debouncer, the
// seven-segment decoder and the board top level.
//   N_SW_DEFAULT          : number of slide switches on the board
//   SYNC_STAGES_DEFAULT   : synchroniser depth per switch
//   TICK_DIV_DEFAULT      : clock cycles per sample tick (1 ms at 50 MHz)
//   STABLE_TICKS_DEFAULT  : consecutive differing ticks needed to accept a level
//   bit_state_t           : per-switch debounce state view
package sw_pkg;

  localparam int N_SW_DEFAULT         = 10;
  localparam int SYNC_STAGES_DEFAULT  = 2;
  localparam int TICK_DIV_DEFAULT     = 50000;
  localparam int STABLE_TICKS_DEFAULT = 10;

  // STABLE: synchronised level matches the debounced output.
  // COUNTING: they differ and the bit is accumulating ticks.
  typedef enum logic {
    ST_STABLE   = 1'b0,
    ST_COUNTING = 1'b1
  } bit_state_t;

endpackage

// File: rtl/debounce_bit.sv
// debounce_bit: synchroniser, stability counter and debounced output for a
// single switch.
//   clk    : system clock, rising edge
//   rst    : synchronous active-high reset
//   tick   : shared sample tick, one cycle wide
//   raw    : asynchronous switch level
//   db     : debounced level (registered)
//   accept : high in the cycle db is about to take a new value
module debounce_bit
  import sw_pkg::*;
#(
  parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,   // minimum 2
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT   // minimum 1
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic raw,
  output logic db,
  output logic accept
);

  localparam int CW = $clog2(STABLE_TICKS + 1);

  logic [SYNC_STAGES-1:0] sync_reg;
  logic [CW-1:0]          cnt_reg;
  logic                   db_reg;
  logic                   sync_bit;
  bit_state_t             state;

  // Plain shift chain; only the last stage is trusted as a clean level.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_reg <= '0;
    end else begin
      sync_reg <= {sync_reg[SYNC_STAGES-2:0], raw};
    end
  end

  assign sync_bit = sync_reg[SYNC_STAGES-1];

  // State is derived, not stored: any cycle where the synchronised level
  // matches the output is STABLE, which is what restarts the count on a
  // bounce back even if it lasts only one cycle.
  always_comb begin
    state = (sync_bit != db_reg) ? ST_COUNTING : ST_STABLE;
  end

  assign accept = (state == ST_COUNTING) && tick &&
                  (cnt_reg == CW'(STABLE_TICKS - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_reg <= '0;
      db_reg  <= 1'b0;
    end else begin
      case (state)
        ST_STABLE: begin
          cnt_reg <= '0;
        end
        ST_COUNTING: begin
          if (accept) begin
            db_reg  <= sync_bit;
            cnt_reg <= '0;
          end else if (tick) begin
            cnt_reg <= cnt_reg + 1'b1;
          end
        end
        default: begin
          cnt_reg <= '0;
        end
      endcase
    end
  end

  assign db = db_reg;

endmodule

// File: rtl/switch_debouncer.sv
// switch_debouncer: synchronises and debounces the slide switches feeding
// the seven-segment decoder.
//   clk        : system clock, rising edge
//   rst        : synchronous active-high reset
//   sw_raw     : asynchronous switch levels from pins
//   sw_db      : debounced switch vector (registered)
//   sw_changed : one-cycle pulse in the cycle sw_db takes a new value
//   sw_legal   : sw_db is zero or has exactly one bit set below the MSB
module switch_debouncer
  import sw_pkg::*;
#(
  parameter int N_SW         = N_SW_DEFAULT,
  parameter int SYNC_STAGES  = SYNC_STAGES_DEFAULT,   // minimum 2
  parameter int TICK_DIV     = TICK_DIV_DEFAULT,      // minimum 1
  parameter int STABLE_TICKS = STABLE_TICKS_DEFAULT   // minimum 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_SW-1:0] sw_raw,
  output logic [N_SW-1:0] sw_db,
  output logic            sw_changed,
  output logic            sw_legal
);

  // Keep the prescaler at least one bit wide so TICK_DIV=1 still elaborates;
  // in that case the count sits at 0 and tick is permanently high.
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [PW-1:0]   presc_reg;
  logic            tick;
  logic [N_SW-1:0] accept_vec;
  logic [N_SW-1:0] db_vec;
  logic            sw_changed_reg;

  // Free-running prescaler, never realigned to switch edges.
  assign tick = (presc_reg == PW'(TICK_DIV - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_reg <= '0;
    end else if (tick) begin
      presc_reg <= '0;
    end else begin
      presc_reg <= presc_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < N_SW; gi++) begin : g_bit
      debounce_bit #(
        .SYNC_STAGES  (SYNC_STAGES),
        .STABLE_TICKS (STABLE_TICKS)
      ) u_bit (
        .clk    (clk),
        .rst    (rst),
        .tick   (tick),
        .raw    (sw_raw[gi]),
        .db     (db_vec[gi]),
        .accept (accept_vec[gi])
      );
    end
  endgenerate

  // Registered alongside the db bits so the pulse lines up with the new value;
  // simultaneous accepts collapse into one pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_changed_reg <= 1'b0;
    end else begin
      sw_changed_reg <= |accept_vec;
    end
  end

  assign sw_db      = db_vec;
  assign sw_changed = sw_changed_reg;
  assign sw_legal   = (db_vec == '0) ||
                      (!db_vec[N_SW-1] && $onehot(db_vec[N_SW-2:0]));

endmodule

// File: tb/tb_switch_debouncer.sv
// Directed bench for switch_debouncer with TICK_DIV=4, STABLE_TICKS=3,
// SYNC_STAGES=2. Expected debounce latency after an input edge applied just
// after a clock edge is 11..14 rising edges depending on prescaler phase.
module tb_switch_debouncer;

  localparam int N = 10;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] sw_raw = '0;
  logic [N-1:0] sw_db;
  logic         sw_changed;
  logic         sw_legal;

  int n_cmp = 0;
  int n_bad = 0;
  int chg_total = 0;

  switch_debouncer #(
    .N_SW         (N),
    .SYNC_STAGES  (2),
    .TICK_DIV     (4),
    .STABLE_TICKS (3)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .sw_raw     (sw_raw),
    .sw_db      (sw_db),
    .sw_changed (sw_changed),
    .sw_legal   (sw_legal)
  );

  always #5 clk = ~clk;

  // sw_changed is registered, so it is stable at the falling edge.
  always @(negedge clk) begin
    if (sw_changed) chg_total++;
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step(input int k);
    repeat (k) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Waits (bounded) for sw_db to reach exp, then checks value, strobe
  // alignment and latency window.
  task automatic wait_db(input string tag, input logic [N-1:0] exp, input int lo, input int hi);
    int  n = 0;
    bit  seen = 0;
    while (!seen && n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (sw_db === exp) seen = 1;
    end
    $display("%s: sw_db=%03h after %0d cycles, sw_changed=%0b sw_legal=%0b",
             tag, sw_db, n, sw_changed, sw_legal);
    check_eq({tag, "_val"}, 32'(sw_db), 32'(exp));
    check_eq({tag, "_strobe"}, 32'(sw_changed), 32'd1);
    check_eq({tag, "_lat"}, 32'(n >= lo && n <= hi), 32'd1);
  endtask

  initial begin
    int base;
    bit bad;

    // Reset with all switches on.
    rst = 1'b1;
    sw_raw = 10'h3FF;
    for (int i = 0; i < 3; i++) begin
      step(1);
      check_eq("rst_db", 32'(sw_db), 32'h0);
      check_eq("rst_chg", 32'(sw_changed), 32'h0);
      check_eq("rst_legal", 32'(sw_legal), 32'h1);
    end
    base = chg_total;
    rst = 1'b0;
    wait_db("rst_release", 10'h3FF, 11, 15);
    check_eq("rst_release_legal", 32'(sw_legal), 32'h0);
    step(3);
    check_eq("rst_release_pulses", 32'(chg_total - base), 32'd1);
    sw_raw = '0;
    wait_db("rst_clear", 10'h000, 11, 15);
    step(3);

    // Clean press.
    base = chg_total;
    sw_raw = 10'h001;
    wait_db("press", 10'h001, 11, 15);
    step(4);
    check_eq("press_pulses", 32'(chg_total - base), 32'd1);
    check_eq("press_legal", 32'(sw_legal), 32'h1);
    sw_raw = '0;
    wait_db("press_release", 10'h000, 11, 15);
    step(3);

    // Bounce on bit 3: 1-cycle highs every 6 cycles never accumulate.
    base = chg_total;
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      sw_raw = (i % 6 == 0) ? 10'h008 : 10'h000;
      step(1);
      if (sw_db[3] !== 1'b0) bad = 1;
    end
    sw_raw = '0;
    step(20);
    $display("bounce: sw_db=%03h pulses=%0d", sw_db, chg_total - base);
    check_eq("bounce_db3", 32'(bad), 32'h0);
    check_eq("bounce_db", 32'(sw_db), 32'h0);
    check_eq("bounce_pulses", 32'(chg_total - base), 32'd0);

    // Two bits at once produce a single pulse; bit 7 plus bit 0 is illegal.
    base = chg_total;
    sw_raw = 10'h081;
    wait_db("simul", 10'h081, 11, 15);
    step(4);
    check_eq("simul_pulses", 32'(chg_total - base), 32'd1);
    check_eq("simul_legal", 32'(sw_legal), 32'h0);
    sw_raw = '0;
    wait_db("simul_release", 10'h000, 11, 15);
    step(3);

    // Top bit alone is illegal; release gives a second pulse.
    base = chg_total;
    sw_raw = 10'h200;
    wait_db("illegal", 10'h200, 11, 15);
    check_eq("illegal_legal", 32'(sw_legal), 32'h0);
    sw_raw = '0;
    wait_db("illegal_release", 10'h000, 11, 15);
    step(3);
    check_eq("illegal_pulses", 32'(chg_total - base), 32'd2);
    check_eq("illegal_release_legal", 32'(sw_legal), 32'h1);

    // Reset in the middle of a count discards it.
    base = chg_total;
    sw_raw = 10'h020;
    step(6);
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(1);
      check_eq("midrst_db", 32'(sw_db), 32'h0);
      check_eq("midrst_chg", 32'(sw_changed), 32'h0);
    end
    rst = 1'b0;
    check_eq("midrst_pulses", 32'(chg_total - base), 32'd0);
    wait_db("midrst_release", 10'h020, 11, 15);
    step(3);
    check_eq("midrst_release_pulses", 32'(chg_total - base), 32'd1);
    check_eq("midrst_legal", 32'(sw_legal), 32'h1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
